// File: rtl/mem_responder_if.sv
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bundle between the core's memory controller
//               and mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output mem_read, mem_write, mem_wrbits, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  mem_read, mem_write, mem_wrbits, addr, wdata,
        output rdata, ready, err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed RAM responder with programmable wait states,
//               byte-lane writes and a one-cycle ready/err completion pulse.
//               Optional macro MEM_RESPONDER_WRBITS_CHECK_EN enables write
//               mask legality checking against addr[1:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wrbits_q, wrbits_d;
    logic                    is_write_q, is_write_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;

    logic                    w_req;
    logic                    w_mask_err;
    logic                    w_acc_err;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_idx_in;
    logic [ADDR_WIDTH-1:0]   w_rd_idx;
    logic [31:0]             w_rd_word;

`ifdef MEM_RESPONDER_WRBITS_CHECK_EN
    function automatic logic wrbits_legal(input logic [3:0] m, input logic [1:0] a);
        case ({m, a})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
            6'b0011_00, 6'b1100_10, 6'b1111_00: wrbits_legal = 1'b1;
            default:                            wrbits_legal = 1'b0;
        endcase
    endfunction

    assign w_mask_err = bus.mem_write & ~wrbits_legal(bus.mem_wrbits, bus.addr[1:0]);
`else
    assign w_mask_err = 1'b0;
`endif

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_idx_in  = bus.addr[ADDR_WIDTH+1:2];
    // Upper address bits beyond the array are an error rather than an alias.
    assign w_acc_err = (bus.mem_read & bus.mem_write)
                     | (|(bus.addr >> (ADDR_WIDTH + 2)))
                     | w_mask_err;
    assign w_rd_idx  = (state_q == ST_IDLE) ? w_idx_in : idx_q;
    assign w_we      = (state_q == ST_RESP) & is_write_q & ~err_q;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clock) begin
            if (w_we && wrbits_q[i]) begin
                lane_mem[idx_q] <= wdata_q[8*i +: 8];
            end
        end

        assign w_rd_word[8*i +: 8] = lane_mem[w_rd_idx];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wrbits_d   = wrbits_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        rdata_d    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    idx_d      = w_idx_in;
                    wdata_d    = bus.wdata;
                    wrbits_d   = bus.mem_wrbits;
                    is_write_d = bus.mem_write;
                    err_d      = w_acc_err;
                    cnt_d      = 4'(WAIT_CYCLES);
                    state_d    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is registered on entry to RESP and self-clears afterwards.
        if (state_d == ST_RESP && !err_d && !is_write_d) begin
            rdata_d = w_rd_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            wrbits_q   <= 4'd0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wrbits_q   <= wrbits_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ready = (state_q == ST_RESP);
    assign bus.err   = (state_q == ST_RESP) & err_q;
    assign bus.rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder with a
//               transaction-level memory model and per-cycle output compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int AW = 12;
    localparam int W  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          exp_cyc     = -1;
    logic        exp_err     = 1'b0;
    logic [31:0] exp_rdata   = 32'd0;
    logic        exp_now;
    int          n_ready     = 0;
    logic [31:0] last_rdata  = 32'd0;
    logic        last_err    = 1'b0;
    logic [31:0] mdl [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Outputs must be all-zero except in the single predicted response cycle.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            exp_now = (cyc == exp_cyc);
            chk("cycle_outputs", {30'd0, bus.ready, bus.err, bus.rdata},
                exp_now ? {30'd0, 1'b1, exp_err, exp_rdata} : 64'd0);
            if (bus.ready) begin
                n_ready++;
                last_rdata = bus.rdata;
                last_err   = bus.err;
            end
        end
    end

    function automatic logic mask_legal(input logic [3:0] m, input logic [1:0] a);
        if (m == 4'b0001 && a == 2'd0) return 1'b1;
        if (m == 4'b0010 && a == 2'd1) return 1'b1;
        if (m == 4'b0100 && a == 2'd2) return 1'b1;
        if (m == 4'b1000 && a == 2'd3) return 1'b1;
        if (m == 4'b0011 && a == 2'd0) return 1'b1;
        if (m == 4'b1100 && a == 2'd2) return 1'b1;
        if (m == 4'b1111 && a == 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic mdl_err(input logic rd, input logic wr,
                                     input logic [3:0] wb, input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (a >= (32'h1 << (AW + 2))) return 1'b1;
`ifdef MEM_RESPONDER_WRBITS_CHECK_EN
        if (wr && !mask_legal(wb, a[1:0])) return 1'b1;
`else
        if (wr && mask_legal(wb, a[1:0]) && 1'b0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input int idx);
        return mdl.exists(idx) ? mdl[idx] : 32'd0;
    endfunction

    task automatic req(input logic rd, input logic wr, input logic [3:0] wb,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic        e;
        logic [31:0] r;
        logic [31:0] word;
        int          idx;
        idx = int'(a / 4);
        e   = mdl_err(rd, wr, wb, a);
        r   = (e || wr) ? 32'd0 : mdl_read(idx);
        if (wr && !e) begin
            word = mdl_read(idx);
            for (int i = 0; i < 4; i++) begin
                if (wb[i]) word[8*i +: 8] = wd[8*i +: 8];
            end
            mdl[idx] = word;
        end
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.mem_wrbits = wb;
        bus.addr       = a;
        bus.wdata      = wd;
        n_ready        = 0;
        last_rdata     = 32'hBAD0BAD0;
        last_err       = 1'bx;
        exp_err        = e;
        exp_rdata      = r;
        exp_cyc        = cyc + 1 + W;
        repeat (W + 1) @(negedge clock);
        repeat (hold) @(negedge clock);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic abort_write(input logic [31:0] a, input logic [31:0] wd);
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.mem_wrbits = 4'b1111;
        bus.addr       = a;
        bus.wdata      = wd;
        n_ready        = 0;
        exp_cyc        = -1;
        @(negedge clock);
        reset         = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_wrbits = 4'd0;
        bus.addr       = 32'd0;
        bus.wdata      = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {30'd0, bus.ready, bus.err, bus.rdata}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        req(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 0);
        chk("wr10_pulses", 64'(n_ready), 64'd1);
        chk("wr10_err", {63'd0, last_err}, 64'd0);
        req(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, 0);
        chk("rd10_data", last_rdata, 32'hDEADBEEF);

        req(1'b0, 1'b1, 4'b1111, 32'h20, 32'h11223344, 0);
        req(1'b0, 1'b1, 4'b0010, 32'h21, 32'h0000AA00, 0);
        req(1'b1, 1'b0, 4'b0000, 32'h20, 32'h0, 0);
        chk("byte_lane", last_rdata, 32'h1122AA44);

        req(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, 10);
        chk("hold_pulses", 64'(n_ready), 64'd1);
        req(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, 0);
        chk("rereq_pulses", 64'(n_ready), 64'd1);

        req(1'b1, 1'b0, 4'b0000, 32'h00010000, 32'h0, 0);
        chk("oor_err", {63'd0, last_err}, 64'd1);
        chk("oor_rdata", last_rdata, 32'd0);

        req(1'b1, 1'b1, 4'b1111, 32'h20, 32'hFFFFFFFF, 0);
        chk("both_err", {63'd0, last_err}, 64'd1);
        req(1'b1, 1'b0, 4'b0000, 32'h20, 32'h0, 0);
        chk("both_nowrite", last_rdata, 32'h1122AA44);

        req(1'b0, 1'b1, 4'b1111, 32'h30, 32'h0, 0);
        abort_write(32'h30, 32'h12345678);
        chk("abort_pulses", 64'(n_ready), 64'd0);
        req(1'b1, 1'b0, 4'b0000, 32'h30, 32'h0, 0);
        chk("abort_nowrite", last_rdata, 32'd0);

        req(1'b0, 1'b1, 4'b1111, 32'h00, 32'hA5A5A5A5, 0);
        req(1'b0, 1'b1, 4'b0011, 32'h02, 32'h0000CAFE, 0);
`ifdef MEM_RESPONDER_WRBITS_CHECK_EN
        chk("mask_err", {63'd0, last_err}, 64'd1);
        req(1'b1, 1'b0, 4'b0000, 32'h00, 32'h0, 0);
        chk("mask_data", last_rdata, 32'hA5A5A5A5);
`else
        chk("mask_err", {63'd0, last_err}, 64'd0);
        req(1'b1, 1'b0, 4'b0000, 32'h00, 32'h0, 0);
        chk("mask_data", last_rdata, 32'hA5A5CAFE);
`endif

        req(1'b0, 1'b1, 4'b0000, 32'h10, 32'h55555555, 0);
        req(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, 0);
        chk("zero_mask", last_rdata, 32'hDEADBEEF);

        req(1'b0, 1'b1, 4'b1111, 32'h3FFC, 32'hCAFEF00D, 0);
        req(1'b0, 1'b1, 4'b0100, 32'h3FFE, 32'h00770000, 0);
        req(1'b1, 1'b0, 4'b0000, 32'h3FFF, 32'h0, 0);
        chk("top_word", last_rdata, 32'hCA77F00D);
        req(1'b0, 1'b1, 4'b1111, 32'h4000, 32'h01234567, 0);
        chk("top_oor_err", {63'd0, last_err}, 64'd1);
        req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data/instruction memory interface.
- Accepts the mem_read / mem_write / mem_wrbits / addr requests the controller issues.
- Performs byte-lane writes and word reads on an internal RAM with programmable wait states, and signals completion with a ready/err handshake.
- Sits between the core datapath and the storage array; replaces the zero-latency behavioural memory.

Parameters:
- ADDR_WIDTH, 12, word-index width; RAM holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between accept and ready (0..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request, held by requester until ready.
- mem_write  input  1  write request, held by requester until ready.
- mem_wrbits  input  4  byte-lane write enables; bit i writes byte i (wdata[8i+7:8i]).
- addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2].
- wdata  input  32  write data.
- rdata  output  32  read data, valid only while ready=1 of a read.
- ready  output  1  one-cycle completion pulse.
- err  output  1  error flag, valid only while ready=1.

Behaviour:
- Reset: state IDLE, rdata=0, ready=0, err=0, wait counter 0. RAM contents are not cleared.
- Reset asserted mid-transaction aborts it. A pending write is not committed.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - If mem_read|mem_write: capture addr, wdata, mem_wrbits and request type, load counter=WAIT_CYCLES, go to WAIT.
  - If WAIT_CYCLES=0, go directly to RESP.
- WAIT: decrement the counter each cycle; at counter==1 go to RESP. Inputs are ignored; captured values are used.
- RESP (exactly one cycle), ready=1:
  - read: rdata=RAM[index].
  - write: lanes with captured mem_wrbits=1 are updated at the clock edge ending RESP; other lanes are unchanged; rdata=0.
  - Next state is HOLD.
- HOLD: ready=0. Stay until mem_read=0 and mem_write=0, then go to IDLE. Each request therefore completes exactly once even if the requester holds it long.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the accept edge.
- rdata and err are forced to 0 whenever ready=0.
- Error cases: err=1 with ready=1, no RAM write, rdata=0:
  - mem_read and mem_write both 1 at accept;
  - addr[31:ADDR_WIDTH+2] nonzero (out of range).
- mem_write with mem_wrbits=0000 completes normally (err=0) with no change to RAM.
- Address wrap: none; out-of-range is an error, not aliased.
- addr[1:0] is ignored for reads. Alignment and sign extension of loads are the datapath's job.

Optional Feature:
- Macro: MEM_RESPONDER_WRBITS_CHECK_EN.
- Defined: on a write, mem_wrbits must be a legal pattern for addr[1:0]:
  - 0001/0010/0100/1000 with addr[1:0]=00/01/10/11;
  - 0011 with addr[1:0]=00, 1100 with addr[1:0]=10;
  - 1111 with addr[1:0]=00.
  - Any other combination, including 0000, gives err=1 with no write.
- Not defined: any mask is applied as given, and addr[1:0] is ignored for writes.

Test Plan:
- Write/read word, WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, wrbits=1111. Expect ready 3 cycles after accept, err=0. Then read addr=0x10 -> rdata=0xDEADBEEF, ready 3 cycles after accept.
- Byte lane: preload 0x11223344 at 0x20. Write addr=0x21, wdata=0x0000AA00, wrbits=0010. Read 0x20 -> 0x1122AA44.
- Hold behaviour: keep mem_read=1 for 10 cycles after ready. Expect exactly one ready pulse, state stays in HOLD. Drop the request, re-assert, and see a second ready after WAIT_CYCLES+1 cycles.
- Errors:
  - read addr=0x00010000 with ADDR_WIDTH=12 -> ready with err=1, rdata=0.
  - mem_read=mem_write=1 -> err=1, RAM unchanged.
- Reset mid-WAIT of a write to 0x30 (old value 0x0): reset=0 for 1 cycle. Expect ready=0, rdata=0, RAM[0x30]=0 on subsequent read.
- With MEM_RESPONDER_WRBITS_CHECK_EN: write addr=0x02, wrbits=0011 -> err=1, no write. Without the macro, the same write updates bytes 0-1.
